// File: rtl/multi_tick_divider.sv
// Multi-channel programmable clock-enable / waveform generator.
// Each channel divides clk by a runtime divisor; align restarts all phases.
module multi_tick_divider #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHANNELS-1:0]  ch_en,
  input  logic                 align,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_ch,
  input  logic [CNT_WIDTH-1:0] cfg_div,
  input  logic                 cfg_mode,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  wave,
  output logic                 cfg_err
);

  localparam logic [CNT_WIDTH-1:0] DIV_RST  = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
  localparam logic [4:0]           CH_LIMIT = 5'(CHANNELS);

  logic [CNT_WIDTH-1:0] div_q [CHANNELS];
  logic [CNT_WIDTH-1:0] div_d [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CHANNELS-1:0]  mode_q, mode_d;
  logic [CHANNELS-1:0]  tick_q, tick_d;
  logic [CHANNELS-1:0]  wave_q, wave_d;
  logic                 cfg_err_q, cfg_err_d;

  logic                 cfg_ok;
  logic [CHANNELS-1:0]  hit;
  logic [CHANNELS-1:0]  run;
  logic [CHANNELS-1:0]  term;

  always_comb begin
    cfg_ok    = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
    cfg_err_d = cfg_we && !cfg_ok;
    hit       = '0;
    run       = '0;
    term      = '0;
    mode_d    = mode_q;
    tick_d    = '0;
    wave_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      div_d[i] = div_q[i];
      cnt_d[i] = '0;
      hit[i]   = cfg_ok && (cfg_ch == 4'(i));
      run[i]   = ch_en[i] && (div_q[i] != '0);
      term[i]  = run[i] && (cnt_q[i] == div_q[i] - ONE);
      if (run[i]) begin
        cnt_d[i]  = term[i] ? '0 : cnt_q[i] + ONE;
        tick_d[i] = term[i];
        wave_d[i] = mode_q[i] ? term[i] : (wave_q[i] ^ term[i]);
      end
      // A write restarts the channel, so a smaller divisor cannot overrun.
      if (hit[i]) begin
        div_d[i]  = cfg_div;
        mode_d[i] = cfg_mode;
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        wave_d[i] = 1'b0;
      end
      if (align) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b0;
        wave_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i] <= DIV_RST;
        cnt_q[i] <= '0;
      end
      mode_q    <= '0;
      tick_q    <= '0;
      wave_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      wave_q    <= wave_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign wave    = wave_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_tick_divider.sv
// Directed self-checking bench for multi_tick_divider.
// Two instances: default sizing and a narrow CNT_WIDTH=4 variant.
module tb_multi_tick_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ch_en;
  logic        align;
  logic        cfg_we;
  logic [3:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  tick, wave;
  logic        cfg_err;

  logic [1:0]  s_ch_en;
  logic        s_align;
  logic        s_cfg_we;
  logic [3:0]  s_cfg_ch;
  logic [3:0]  s_cfg_div;
  logic        s_cfg_mode;
  logic [1:0]  s_tick, s_wave;
  logic        s_cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_tick_divider #(
    .CHANNELS(4), .CNT_WIDTH(16), .DEFAULT_DIV(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ch_en(ch_en), .align(align),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .tick(tick), .wave(wave), .cfg_err(cfg_err)
  );

  multi_tick_divider #(
    .CHANNELS(2), .CNT_WIDTH(4), .DEFAULT_DIV(9)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .ch_en(s_ch_en), .align(s_align),
    .cfg_we(s_cfg_we), .cfg_ch(s_cfg_ch), .cfg_div(s_cfg_div),
    .cfg_mode(s_cfg_mode), .tick(s_tick), .wave(s_wave),
    .cfg_err(s_cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] ch, input logic [15:0] dv,
                    input logic md);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_div  = dv;
    cfg_mode = md;
  endtask

  int first0, first1, firsts, last0, lasts, n0, n1, ns, mism, other;
  logic w16, w31, w32, e2, e3, w5, w10, w15;
  logic [31:0] mask1;

  initial begin
    rst_n = 1'b0; ch_en = '0; align = 1'b0; cfg_we = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;
    s_ch_en = '0; s_align = 1'b0; s_cfg_we = 1'b0;
    s_cfg_ch = '0; s_cfg_div = '0; s_cfg_mode = 1'b0;

    step(2);
    chk("rst_tick", 32'(tick), 0);
    chk("rst_wave", 32'(wave), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_s_tick", 32'({s_tick, s_wave}), 0);

    // default divisor 16 on channel 0
    rst_n = 1'b1;
    ch_en = 4'b0001;
    first0 = 0; last0 = 0; n0 = 0; other = 0;
    for (int k = 1; k <= 48; k++) begin
      step(1);
      if (tick[0]) begin
        n0++;
        last0 = k;
        if (first0 == 0) first0 = k;
      end
      if (tick[3:1] != 3'b000) other++;
      if (k == 16) w16 = wave[0];
      if (k == 31) w31 = wave[0];
      if (k == 32) w32 = wave[0];
    end
    chk("def_first", 32'(first0), 16);
    chk("def_count", 32'(n0), 3);
    chk("def_last", 32'(last0), 48);
    chk("def_other", 32'(other), 0);
    chk("def_w16", 32'(w16), 1);
    chk("def_w31", 32'(w31), 1);
    chk("def_w32", 32'(w32), 0);

    // ch1 pulse mode, div 3
    wr(4'd1, 16'd3, 1'b1);
    ch_en = 4'b0011;
    step(1);
    cfg_we = 1'b0;
    chk("wr_tick", 32'(tick), 0);
    n1 = 0; mism = 0; first0 = 0;
    for (int j = 1; j <= 15; j++) begin
      step(1);
      if (tick[1]) n1++;
      if (tick[1] != (j % 3 == 0)) mism++;
      if (wave[1] != tick[1]) mism++;
      if (tick[0] && first0 == 0) first0 = j;
    end
    chk("p3_count", 32'(n1), 5);
    chk("p3_mism", 32'(mism), 0);
    chk("p3_ch0", 32'(first0), 15);

    // ch2 div 1 toggle
    wr(4'd2, 16'd1, 1'b0);
    ch_en = 4'b0111;
    step(1);
    cfg_we = 1'b0;
    n1 = 0; mism = 0;
    for (int j = 1; j <= 6; j++) begin
      step(1);
      if (tick[2]) n1++;
      if (wave[2] != (j % 2 == 1)) mism++;
    end
    chk("d1_tick", 32'(n1), 6);
    chk("d1_wave", 32'(mism), 0);
    wr(4'd2, 16'd0, 1'b0);
    other = 0;
    for (int j = 1; j <= 4; j++) begin
      step(1);
      cfg_we = 1'b0;
      if (tick[2] || wave[2]) other++;
    end
    chk("d0_idle", 32'(other), 0);

    // align with ch0 div 16, ch1 div 5, plus a rejected write
    ch_en = 4'b0011;
    wr(4'd1, 16'd5, 1'b0);
    step(1);
    cfg_we = 1'b0;
    step(7);
    align = 1'b1;
    step(1);
    align = 1'b0;
    chk("al_wave", 32'(wave), 0);
    chk("al_tick", 32'(tick), 0);
    first0 = 0; first1 = 0; n1 = 0;
    for (int j = 1; j <= 16; j++) begin
      step(1);
      if (tick[0] && first0 == 0) first0 = j;
      if (tick[1]) begin
        n1++;
        if (first1 == 0) first1 = j;
      end
      if (j == 5) w5 = wave[1];
      if (j == 2) e2 = cfg_err;
      if (j == 3) e3 = cfg_err;
      if (j == 1) wr(4'd7, 16'd2, 1'b1);
      if (j == 2) cfg_we = 1'b0;
    end
    chk("al_ch0", 32'(first0), 16);
    chk("al_ch1", 32'(first1), 5);
    chk("al_cnt1", 32'(n1), 3);
    chk("al_w5", 32'(w5), 1);
    chk("err_hi", 32'(e2), 1);
    chk("err_lo", 32'(e3), 0);

    // write landing on ch1 terminal cycle
    align = 1'b1;
    step(1);
    align = 1'b0;
    mask1 = '0;
    for (int j = 1; j <= 15; j++) begin
      step(1);
      if (tick[1]) mask1[j] = 1'b1;
      if (j == 10) w10 = wave[1];
      if (j == 15) w15 = wave[1];
      if (j == 9) wr(4'd1, 16'd5, 1'b0);
      if (j == 10) cfg_we = 1'b0;
    end
    chk("term_mask", mask1, 32'h0000_8020);
    chk("term_w10", 32'(w10), 0);
    chk("term_w15", 32'(w15), 1);

    // narrow counter, div 15 pulse mode
    s_cfg_we = 1'b1; s_cfg_ch = 4'd0; s_cfg_div = 4'd15; s_cfg_mode = 1'b1;
    s_ch_en = 2'b01;
    step(1);
    s_cfg_we = 1'b0;
    firsts = 0; lasts = 0; ns = 0; mism = 0;
    for (int j = 1; j <= 30; j++) begin
      step(1);
      if (s_tick[0]) begin
        ns++;
        lasts = j;
        if (firsts == 0) firsts = j;
      end
      if (s_wave[0] != s_tick[0]) mism++;
    end
    chk("s15_first", 32'(firsts), 15);
    chk("s15_count", 32'(ns), 2);
    chk("s15_last", 32'(lasts), 30);
    chk("s15_wave", 32'(mism), 0);

    // mid-count reset restores default divisors
    step(5);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mr_out", 32'({tick, wave, cfg_err}), 0);
    chk("mr_s_out", 32'({s_tick, s_wave}), 0);
    first0 = 0; first1 = 0; firsts = 0;
    for (int j = 1; j <= 16; j++) begin
      step(1);
      if (tick[0] && first0 == 0) first0 = j;
      if (tick[1] && first1 == 0) first1 = j;
      if (s_tick[0] && firsts == 0) firsts = j;
    end
    chk("mr_ch0", 32'(first0), 16);
    chk("mr_ch1", 32'(first1), 16);
    chk("mr_small", 32'(firsts), 9);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
